// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 digest serializer: digest width, the
// serializer FSM state encoding, header beat field positions and the set of
// ring widths the serializer can be built for.
// No ports (package).
// ---------------------------------------------------------------------------
package sha256_pkg;

    localparam int DigestWidth = 256;

    // Ring widths the serializer supports; each divides the digest evenly.
    localparam int NumRingWidths = 4;
    localparam int RingWidths [NumRingWidths] = '{32, 64, 128, 256};

    // Header beat layout. The node id occupies the top byte of the beat, so
    // its position depends on the ring width; the beat count sits in the
    // bottom byte regardless of width.
    localparam int HdrIdWidth  = 8;
    localparam int HdrCountMsb = 7;
    localparam int HdrCountLsb = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHdr  = 2'd1,
        StData = 2'd2
    } state_e;

    function automatic int hdrIdMsb(input int ringWidth);
        return ringWidth - 1;
    endfunction

    function automatic int hdrIdLsb(input int ringWidth);
        return ringWidth - HdrIdWidth;
    endfunction

    function automatic bit ringWidthOk(input int ringWidth);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < NumRingWidths; i++) begin
            if (RingWidths[i] == ringWidth) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

    // Counter must be able to hold N itself (one past the last beat index),
    // and a zero-width counter is not legal.
    function automatic int beatCountWidth(input int numBeats);
        int w;
        w = $clog2(numBeats + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bsg_dff_en.sv
// ---------------------------------------------------------------------------
// bsg_dff_en
// Plain enable-gated register with no reset.
// Ports:
//   clk_i   - clock
//   en_i    - load enable; data_i is captured on the rising edge when high
//   data_i  - value to capture
//   data_o  - registered value
// ---------------------------------------------------------------------------
module bsg_dff_en #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q;

    // Hold the stored value until a load is requested; contents before the
    // first load are meaningless to every user of this register.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/sha256_beat_counter.sv
// ---------------------------------------------------------------------------
// sha256_beat_counter
// Data beat index for the digest serializer.
// Ports:
//   clk_i    - clock
//   reset_i  - synchronous active-high reset, clears the count
//   clear_i  - clear the count to 0 (takes priority over incr_i)
//   incr_i   - advance the count by one
//   count_o  - current beat index
//   last_o   - high while the count equals last_p (final data beat)
// ---------------------------------------------------------------------------
module sha256_beat_counter #(
    parameter int width_p = 4,
    parameter int last_p  = 7
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               incr_i,
    output logic [width_p-1:0] count_o,
    output logic               last_o
);

    localparam logic [width_p-1:0] LastVal = width_p'(last_p);

    logic [width_p-1:0] count_q;
    logic [width_p-1:0] count_d;

    // Clear wins over increment so a new packet always starts from beat 0.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (incr_i) begin
            count_d = count_q + width_p'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == LastVal);

endmodule

// File: rtl/sha256_digest_serializer.sv
// ---------------------------------------------------------------------------
// sha256_digest_serializer
// Takes a 256-bit digest from the SHA-256 core and sends it onto the ring as
// one header beat followed by 256/ring_width_p data beats, most significant
// slice first. Only one digest is held at a time.
// Parameters:
//   ring_width_p - ring beat width, one of 32/64/128/256
//   id_p         - node id; the low byte goes into the header beat
// Ports:
//   clk_i    - clock
//   reset_i  - synchronous active-high reset
//   en_i     - block enable; low freezes all state and hides the outputs
//   v_i      - digest valid from the core
//   data_i   - digest, bits [255:224] are H0
//   ready_o  - a digest can be accepted this cycle
//   v_o      - data_o holds a valid ring beat
//   data_o   - ring beat, zero when v_o is low
//   yumi_i   - ring consumer takes the current beat
// ---------------------------------------------------------------------------
module sha256_digest_serializer
    import sha256_pkg::*;
#(
    parameter int ring_width_p = 32,
    parameter int id_p         = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    en_i,
    input  logic                    v_i,
    input  logic [DigestWidth-1:0]  data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [ring_width_p-1:0] data_o,
    input  logic                    yumi_i
);

    localparam int NumBeats = DigestWidth / ring_width_p;
    localparam int CntWidth = beatCountWidth(NumBeats);
    localparam int IdMsb    = hdrIdMsb(ring_width_p);
    localparam int IdLsb    = hdrIdLsb(ring_width_p);

    localparam logic [HdrIdWidth-1:0]               IdByte    = HdrIdWidth'(id_p);
    localparam logic [HdrCountMsb-HdrCountLsb:0]    CountByte = (HdrCountMsb - HdrCountLsb + 1)'(NumBeats);

    if (!ringWidthOk(ring_width_p)) begin : gBadRingWidth
        $error("sha256_digest_serializer: ring_width_p must be 32, 64, 128 or 256");
    end

    state_e                  state_q;
    state_e                  state_d;
    logic                    accept;
    logic                    yumiEff;
    logic                    active;
    logic                    cntClear;
    logic                    cntIncr;
    logic                    lastBeat;
    logic [CntWidth-1:0]     beatCnt;
    logic [DigestWidth-1:0]  digest_q;
    logic [ring_width_p-1:0] header;
    logic [ring_width_p-1:0] beatData;

    // Reset and a low enable both hide the block completely from both sides.
    assign active  = en_i & ~reset_i;
    assign accept  = v_i & ready_o;
    assign yumiEff = yumi_i & v_o;

    // The single digest buffer only loads on acceptance, so it is frozen for
    // the whole packet regardless of what the core does with data_i.
    bsg_dff_en #(
        .width_p(DigestWidth)
    ) digestReg (
        .clk_i  (clk_i),
        .en_i   (accept),
        .data_i (data_i),
        .data_o (digest_q)
    );

    // The count restarts both on acceptance and when the header is taken, so
    // the first data beat is always slice 0.
    assign cntClear = accept | ((state_q == StHdr) & yumiEff);
    assign cntIncr  = (state_q == StData) & yumiEff;

    sha256_beat_counter #(
        .width_p(CntWidth),
        .last_p (NumBeats - 1)
    ) beatCounter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (cntClear),
        .incr_i  (cntIncr),
        .count_o (beatCnt),
        .last_o  (lastBeat)
    );

    // Header beat: id in the top byte, beat count in the bottom byte.
    always_comb begin
        header                          = '0;
        header[IdMsb:IdLsb]             = IdByte;
        header[HdrCountMsb:HdrCountLsb] = CountByte;
    end

    // Select the digest slice for the current beat, H0 end first.
    always_comb begin
        beatData = '0;
        for (int k = 0; k < NumBeats; k++) begin
            if (beatCnt == CntWidth'(k)) begin
                beatData = digest_q[DigestWidth-1-k*ring_width_p -: ring_width_p];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. accept and yumiEff are already gated by enable and
    // reset, so a disabled block simply holds its state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept)              state_d = StHdr;
            StHdr:  if (yumiEff)             state_d = StData;
            StData: if (yumiEff && lastBeat) state_d = StIdle;
            default:                         state_d = StIdle;
        endcase
    end

    // Output logic. Everything defaults to zero so data_o is clean whenever
    // there is no valid beat.
    always_comb begin
        ready_o = 1'b0;
        v_o     = 1'b0;
        data_o  = '0;
        if (active) begin
            case (state_q)
                StIdle: ready_o = 1'b1;
                StHdr: begin
                    v_o    = 1'b1;
                    data_o = header;
                end
                StData: begin
                    v_o    = 1'b1;
                    data_o = beatData;
                end
                default: ;
            endcase
        end
    end

    // A consumer taking a beat that is not offered is a protocol error.
    yumiWithoutValid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// ---------------------------------------------------------------------------
// tb_sha256_digest_serializer
// Self-checking bench for sha256_digest_serializer. Three instances cover the
// 32/64/256-bit ring widths; 'sel' routes the shared stimulus to one of them
// and muxes its outputs back. Expected beats are produced by pushModel into
// expQ when a digest is accepted and popped as the DUT hands beats over.
// ---------------------------------------------------------------------------
module tb_sha256_digest_serializer;

    localparam logic [255:0] AbcDigest =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] AltDigest =
        256'h01234567_89abcdef_fedcba98_76543210_deadbeef_cafef00d_11223344_55667788;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         vIn;
    logic         yumi;
    logic [255:0] dataIn;
    int           sel;

    logic         rdy32, v32, rdy64, v64, rdy256, v256;
    logic [31:0]  d32;
    logic [63:0]  d64;
    logic [255:0] d256;

    logic         rdy;
    logic         vOut;
    logic [255:0] dOut;

    logic [255:0] expQ [$];
    int           checks;
    int           errors;

    always #5 clk = ~clk;

    sha256_digest_serializer #(.ring_width_p(32), .id_p(5)) dut32 (
        .clk_i(clk), .reset_i(reset), .en_i(en), .v_i(vIn && sel == 0), .data_i(dataIn),
        .ready_o(rdy32), .v_o(v32), .data_o(d32), .yumi_i(yumi && sel == 0)
    );

    sha256_digest_serializer #(.ring_width_p(64), .id_p(8'h17)) dut64 (
        .clk_i(clk), .reset_i(reset), .en_i(en), .v_i(vIn && sel == 1), .data_i(dataIn),
        .ready_o(rdy64), .v_o(v64), .data_o(d64), .yumi_i(yumi && sel == 1)
    );

    sha256_digest_serializer #(.ring_width_p(256), .id_p(8'hA3)) dut256 (
        .clk_i(clk), .reset_i(reset), .en_i(en), .v_i(vIn && sel == 2), .data_i(dataIn),
        .ready_o(rdy256), .v_o(v256), .data_o(d256), .yumi_i(yumi && sel == 2)
    );

    // Route the selected instance's outputs onto the common observation nets.
    always_comb begin
        case (sel)
            0:       begin rdy = rdy32;  vOut = v32;  dOut = {224'b0, d32}; end
            1:       begin rdy = rdy64;  vOut = v64;  dOut = {192'b0, d64}; end
            default: begin rdy = rdy256; vOut = v256; dOut = d256;          end
        endcase
    end

    // Reference packet: header then slices of the digest, MS slice first.
    function automatic void pushModel(input int w, input logic [7:0] id, input logic [255:0] d);
        int           n;
        logic [255:0] mask;
        logic [255:0] hdr;
        n    = 256 / w;
        mask = (256'(1) << w) - 256'(1);
        hdr  = (256'(id) << (w - 8)) | 256'(n);
        expQ.push_back(hdr);
        for (int k = 0; k < n; k++) begin
            expQ.push_back((d >> (256 - (k + 1) * w)) & mask);
        end
    endfunction

    // Advance to just after the next rising edge.
    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Offer a digest until it is accepted; returns one cycle after acceptance.
    task automatic sendDigest(input logic [255:0] d, output bit ok);
        ok     = 1'b0;
        yumi   = 1'b0;
        vIn    = 1'b1;
        dataIn = d;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rdy === 1'b1) begin
                ok = 1'b1;
                waitCycle();
                break;
            end
            waitCycle();
        end
        vIn = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL accept_timeout: ready=%b after 20 cycles, required 1", rdy);
        end
    endtask

    task automatic test_reset();
        sel    = 0;
        reset  = 1'b1;
        vIn    = 1'b1;
        dataIn = AbcDigest;
        waitCycle();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (rdy !== 1'b0 || vOut !== 1'b0 || dOut !== 256'b0) begin
                errors++;
                $display("[TB] FAIL reset_outputs: ready=%b v=%b data=%h, required 0/0/0", rdy, vOut, dOut);
            end
            waitCycle();
        end
        reset = 1'b0;
        vIn   = 1'b0;
        #1;
        checks++;
        if (rdy !== 1'b1 || vOut !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: ready=%b v=%b, required 1/0", rdy, vOut);
        end
        waitCycle();
    endtask

    task automatic test_abc_stream();
        bit           ok;
        logic [255:0] exp;
        sel = 0;
        sendDigest(AbcDigest, ok);
        if (ok) begin
            expQ.push_back(256'h05000008);
            expQ.push_back(256'hba7816bf);
            expQ.push_back(256'h8f01cfea);
            expQ.push_back(256'h414140de);
            expQ.push_back(256'h5dae2223);
            expQ.push_back(256'hb00361a3);
            expQ.push_back(256'h96177a9c);
            expQ.push_back(256'hb410ff61);
            expQ.push_back(256'hf20015ad);
            for (int k = 0; k < 9; k++) begin
                #1;
                exp = expQ.pop_front();
                checks++;
                if (vOut !== 1'b1 || dOut !== exp) begin
                    errors++;
                    $display("[TB] FAIL abc_beat%0d: v=%b data=%h, required v=1 data=%h", k, vOut, dOut, exp);
                end
                yumi = 1'b1;
                waitCycle();
            end
            yumi = 1'b0;
            #1;
            checks++;
            if (rdy !== 1'b1 || vOut !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abc_ready_after: ready=%b v=%b, required 1/0", rdy, vOut);
            end
            waitCycle();
        end
        expQ.delete();
    endtask

    task automatic test_random_stall();
        bit           ok;
        bit           take;
        bit           prevStall;
        logic [255:0] prevData;
        logic [255:0] exp;
        sel       = 0;
        prevStall = 1'b0;
        prevData  = '0;
        sendDigest(AbcDigest, ok);
        if (ok) begin
            pushModel(32, 8'h05, AbcDigest);
            for (int c = 0; c < 300 && expQ.size() > 0; c++) begin
                #1;
                if (vOut === 1'b1) begin
                    if (prevStall) begin
                        checks++;
                        if (dOut !== prevData) begin
                            errors++;
                            $display("[TB] FAIL stall_stable: data=%h, required %h", dOut, prevData);
                        end
                    end
                    take = ($urandom_range(0, 99) < 30);
                    yumi = take;
                    if (take) begin
                        exp = expQ.pop_front();
                        checks++;
                        if (dOut !== exp) begin
                            errors++;
                            $display("[TB] FAIL stall_beat: data=%h, required %h", dOut, exp);
                        end
                    end
                    prevStall = !take;
                    prevData  = dOut;
                end else begin
                    yumi      = 1'b0;
                    prevStall = 1'b0;
                    checks++;
                    errors++;
                    $display("[TB] FAIL stall_valid: v=%b mid-packet, required 1", vOut);
                end
                waitCycle();
            end
            yumi = 1'b0;
            checks++;
            if (expQ.size() != 0) begin
                errors++;
                $display("[TB] FAIL stall_timeout: %0d beats outstanding, required 0", expQ.size());
            end
            #1;
            checks++;
            if (rdy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_ready_after: ready=%b, required 1", rdy);
            end
            waitCycle();
        end
        expQ.delete();
    endtask

    task automatic test_width256();
        bit           ok;
        logic [255:0] exp;
        sel = 2;
        sendDigest(AltDigest, ok);
        if (ok) begin
            expQ.push_back({8'hA3, 240'b0, 8'h01});
            expQ.push_back(AltDigest);
            for (int k = 0; k < 2; k++) begin
                #1;
                exp = expQ.pop_front();
                checks++;
                if (vOut !== 1'b1 || dOut !== exp) begin
                    errors++;
                    $display("[TB] FAIL w256_beat%0d: v=%b data=%h, required v=1 data=%h", k, vOut, dOut, exp);
                end
                yumi = 1'b1;
                waitCycle();
            end
            yumi = 1'b0;
            #1;
            checks++;
            if (rdy !== 1'b1 || vOut !== 1'b0) begin
                errors++;
                $display("[TB] FAIL w256_ready_after: ready=%b v=%b, required 1/0", rdy, vOut);
            end
            waitCycle();
        end
        expQ.delete();
    endtask

    task automatic test_reset_mid_packet();
        bit           ok;
        logic [255:0] exp;
        sel = 0;
        sendDigest(AltDigest, ok);
        if (ok) begin
            pushModel(32, 8'h05, AltDigest);
            for (int k = 0; k < 4; k++) begin
                #1;
                exp = expQ.pop_front();
                checks++;
                if (vOut !== 1'b1 || dOut !== exp) begin
                    errors++;
                    $display("[TB] FAIL midrst_beat%0d: v=%b data=%h, required v=1 data=%h", k, vOut, dOut, exp);
                end
                yumi = 1'b1;
                waitCycle();
            end
            yumi  = 1'b0;
            reset = 1'b1;
            for (int i = 0; i < 2; i++) begin
                #1;
                checks++;
                if (vOut !== 1'b0 || dOut !== 256'b0 || rdy !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL midrst_hold: v=%b data=%h ready=%b, required 0/0/0", vOut, dOut, rdy);
                end
                waitCycle();
            end
            reset = 1'b0;
            #1;
            checks++;
            if (rdy !== 1'b1 || vOut !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midrst_release: ready=%b v=%b, required 1/0", rdy, vOut);
            end
            expQ.delete();
            waitCycle();
        end
        sendDigest(AbcDigest, ok);
        if (ok) begin
            pushModel(32, 8'h05, AbcDigest);
            for (int k = 0; k < 9; k++) begin
                #1;
                exp = expQ.pop_front();
                checks++;
                if (vOut !== 1'b1 || dOut !== exp) begin
                    errors++;
                    $display("[TB] FAIL midrst_fresh%0d: v=%b data=%h, required v=1 data=%h", k, vOut, dOut, exp);
                end
                yumi = 1'b1;
                waitCycle();
            end
            yumi = 1'b0;
            waitCycle();
        end
        expQ.delete();
    endtask

    task automatic test_enable_freeze();
        bit           ok;
        logic [255:0] exp;
        sel = 1;
        sendDigest(AbcDigest, ok);
        if (ok) begin
            pushModel(64, 8'h17, AbcDigest);
            for (int k = 0; k < 5; k++) begin
                if (k == 3) begin
                    yumi = 1'b0;
                    en   = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        #1;
                        checks++;
                        if (vOut !== 1'b0 || rdy !== 1'b0 || dOut !== 256'b0) begin
                            errors++;
                            $display("[TB] FAIL en_freeze%0d: v=%b ready=%b data=%h, required 0/0/0", i, vOut, rdy, dOut);
                        end
                        waitCycle();
                    end
                    en = 1'b1;
                end
                #1;
                exp = expQ.pop_front();
                checks++;
                if (vOut !== 1'b1 || dOut !== exp) begin
                    errors++;
                    $display("[TB] FAIL en_beat%0d: v=%b data=%h, required v=1 data=%h", k, vOut, dOut, exp);
                end
                yumi = 1'b1;
                waitCycle();
            end
            yumi = 1'b0;
            #1;
            checks++;
            if (rdy !== 1'b1 || vOut !== 1'b0) begin
                errors++;
                $display("[TB] FAIL en_ready_after: ready=%b v=%b, required 1/0", rdy, vOut);
            end
            waitCycle();
        end
        expQ.delete();
    endtask

    task automatic test_back_to_back();
        logic [255:0] exp;
        sel    = 0;
        yumi   = 1'b0;
        vIn    = 1'b1;
        dataIn = AltDigest;
        #1;
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_first_ready: ready=%b, required 1", rdy);
        end
        waitCycle();
        pushModel(32, 8'h05, AltDigest);
        for (int k = 0; k < 9; k++) begin
            dataIn = ~dataIn ^ {8{32'(k)}};
            #1;
            exp = expQ.pop_front();
            checks++;
            if (vOut !== 1'b1 || dOut !== exp || rdy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_first%0d: v=%b ready=%b data=%h, required v=1 ready=0 data=%h", k, vOut, rdy, dOut, exp);
            end
            yumi = 1'b1;
            waitCycle();
        end
        yumi   = 1'b0;
        dataIn = AbcDigest;
        #1;
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_second_ready: ready=%b, required 1", rdy);
        end
        waitCycle();
        vIn = 1'b0;
        pushModel(32, 8'h05, AbcDigest);
        for (int k = 0; k < 9; k++) begin
            #1;
            exp = expQ.pop_front();
            checks++;
            if (vOut !== 1'b1 || dOut !== exp) begin
                errors++;
                $display("[TB] FAIL b2b_second%0d: v=%b data=%h, required v=1 data=%h", k, vOut, dOut, exp);
            end
            yumi = 1'b1;
            waitCycle();
        end
        yumi = 1'b0;
        #1;
        checks++;
        if (rdy !== 1'b1 || vOut !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_ready_after: ready=%b v=%b, required 1/0", rdy, vOut);
        end
        waitCycle();
        expQ.delete();
    endtask

    initial begin
        reset  = 1'b1;
        en     = 1'b1;
        vIn    = 1'b0;
        yumi   = 1'b0;
        dataIn = '0;
        sel    = 0;
        checks = 0;
        errors = 0;
        test_reset();
        test_abc_stream();
        test_random_stall();
        test_width256();
        test_reset_mid_packet();
        test_enable_freeze();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
